// File: rtl/serial_pkg.sv
// Shared state encoding and default sizing for the serial frame sender.
package serial_pkg;

    localparam int M_DEFAULT   = 5;
    localparam int DIV_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

endpackage

// File: rtl/piso_shift_ones.sv
// Parallel-in serial-out shifter that fills with ones, so the line drifts back
// to idle-high by itself once the loaded word has been shifted out.
module piso_shift_ones #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] bus_in,
    input  logic         set,
    input  logic         shift,
    output logic         bit_out
);

    logic [W-1:0] sr;

    // A load wins over a shift arriving on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '1;
        end else if (set) begin
            sr <= bus_in;
        end else if (shift) begin
            sr <= {1'b1, sr[W-1:1]};
        end
    end

    assign bit_out = sr[0];

endmodule

// File: rtl/serial_frame_sender.sv
// Serialises M-bit words as start/data/stop frames, each bit held for DIV clocks.
// The FSM and counters live here; the actual bit sequence comes from the shifter.
module serial_frame_sender
    import serial_pkg::*;
#(
    parameter int M   = M_DEFAULT,
    parameter int DIV = DIV_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [M-1:0] data_in,
    input  logic         valid,
    output logic         ready,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(M + 2);
    localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_PENULT = DW'((DIV > 1) ? DIV - 2 : 0);
    localparam logic [BW-1:0] BIT_LAST   = BW'(M);

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic          load;
    logic          shift;

    assign load  = ready && valid;
    assign shift = (state == DATA) && (div_cnt == DIV_LAST);

    piso_shift_ones #(
        .W(M + 1)
    ) u_shift (
        .clk    (clk),
        .reset  (reset),
        .bus_in ({data_in, 1'b0}),
        .set    (load),
        .shift  (shift),
        .bit_out(tx)
    );

    // done is registered one edge early so it lands on the last STOP cycle;
    // with DIV=1 that cycle is the only STOP cycle, entered straight from DATA.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        state   <= DATA;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                DATA: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state <= STOP;
                            done  <= (DIV == 1);
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (div_cnt == DIV_LAST) begin
                        state   <= IDLE;
                        div_cnt <= '0;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                        done    <= (div_cnt == DIV_PENULT);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_sender.sv
// Directed bench for serial_frame_sender: a default M=5/DIV=4 instance plus a
// minimal M=1/DIV=1 instance, checked at falling edges against literal frames.
module tb_serial_frame_sender;

    logic       clk;
    logic       reset;
    logic [4:0] data_in;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       done;

    logic [0:0] data1;
    logic       valid1;
    logic       ready1;
    logic       tx1;
    logic       busy1;
    logic       done1;

    int checks   = 0;
    int failures = 0;

    serial_frame_sender #(
        .M  (5),
        .DIV(4)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .data_in(data_in),
        .valid  (valid),
        .ready  (ready),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    serial_frame_sender #(
        .M  (1),
        .DIV(1)
    ) u_dut1 (
        .clk    (clk),
        .reset  (reset),
        .data_in(data1),
        .valid  (valid1),
        .ready  (ready1),
        .tx     (tx1),
        .busy   (busy1),
        .done   (done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_tx"}, tx, 1'b1);
        check_output({tag, "_busy"}, busy, 1'b0);
        check_output({tag, "_ready"}, ready, 1'b1);
        check_output({tag, "_done"}, done, 1'b0);
    endtask

    // Acceptance is the posedge just before cycle 1; bits[k] is the k-th bit on the line.
    task automatic watch_frame(input logic [6:0] bits, input string tag, input logic hold_valid,
                               input int act_cycle, input logic act_valid, input logic [4:0] act_data);
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk);
            check_output($sformatf("%s_c%0d_tx", tag, c), tx, bits[(c - 1) / 4]);
            check_output($sformatf("%s_c%0d_busy", tag, c), busy, 1'b1);
            check_output($sformatf("%s_c%0d_ready", tag, c), ready, 1'b0);
            check_output($sformatf("%s_c%0d_done", tag, c), done, (c == 28));
            if (c == 1 && !hold_valid) valid = 1'b0;
            if (c == act_cycle) begin
                valid   = act_valid;
                data_in = act_data;
            end
        end
    endtask

    initial begin
        logic [6:0] cut_bits;
        logic [2:0] bits1;

        reset = 1'b0; valid = 1'b0; data_in = '0; valid1 = 1'b0; data1 = '0;
        #1 reset = 1'b1;
        #2;
        check_idle("reset_async");
        check_output("reset_async_tx1", tx1, 1'b1);
        check_output("reset_async_busy1", busy1, 1'b0);
        check_output("reset_async_ready1", ready1, 1'b1);
        @(negedge clk);
        check_idle("reset_held");

        $display("[TB] single frame 10110, accepted on first edge after reset");
        reset = 1'b0; valid = 1'b1; data_in = 5'b10110;
        watch_frame(7'b1101100, "single", 1'b0, 0, 1'b0, 5'b00000);
        @(negedge clk); check_idle("single_gap");
        @(negedge clk); check_idle("single_quiet");

        $display("[TB] back-to-back 00001 then 11111");
        valid = 1'b1; data_in = 5'b00001;
        watch_frame(7'b1000010, "b2b_first", 1'b1, 2, 1'b1, 5'b11111);
        @(negedge clk); check_idle("b2b_gap");
        watch_frame(7'b1111110, "b2b_second", 1'b0, 0, 1'b0, 5'b00000);
        @(negedge clk); check_idle("b2b_after");

        $display("[TB] new word offered while busy");
        valid = 1'b1; data_in = 5'b01101;
        watch_frame(7'b1011010, "ignore_cur", 1'b0, 10, 1'b1, 5'b00000);
        @(negedge clk); check_idle("ignore_gap");
        watch_frame(7'b1000000, "ignore_next", 1'b0, 0, 1'b0, 5'b00000);
        @(negedge clk); check_idle("ignore_after");

        $display("[TB] reset in the middle of a frame");
        valid = 1'b1; data_in = 5'b10100;
        cut_bits = 7'b1101000;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) valid = 1'b0;
            check_output($sformatf("cut_c%0d_tx", c), tx, cut_bits[(c - 1) / 4]);
        end
        @(negedge clk);
        check_output("cut_c12_tx", tx, 1'b0);
        check_output("cut_c12_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check_idle("cut_reset_now");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_idle($sformatf("cut_reset_hold%0d", c));
        end
        reset = 1'b0; valid = 1'b1; data_in = 5'b10110;
        watch_frame(7'b1101100, "cut_resend", 1'b0, 0, 1'b0, 5'b00000);
        @(negedge clk); check_idle("cut_after");

        $display("[TB] M=1 DIV=1 frame");
        valid1 = 1'b1; data1 = 1'b1;
        bits1 = 3'b110;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) valid1 = 1'b0;
            check_output($sformatf("tiny_c%0d_tx", c), tx1, bits1[c - 1]);
            check_output($sformatf("tiny_c%0d_busy", c), busy1, 1'b1);
            check_output($sformatf("tiny_c%0d_ready", c), ready1, 1'b0);
            check_output($sformatf("tiny_c%0d_done", c), done1, (c == 3));
        end
        @(negedge clk);
        check_output("tiny_after_tx", tx1, 1'b1);
        check_output("tiny_after_busy", busy1, 1'b0);
        check_output("tiny_after_ready", ready1, 1'b1);
        check_output("tiny_after_done", done1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_frame_sender.md
SERIAL_FRAME_SENDER -- requirements
Module: serial_frame_sender

Interface
REQ-001 Parameter: M, default 5, number of data bits per frame (M >= 1).
REQ-002 Parameter: DIV, default 4, clock cycles per transmitted bit (DIV >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port data_in, input, M bits: the word to send, sampled on acceptance.
REQ-006 The block SHALL have port valid, input, 1 bit: data_in holds a word to send.
REQ-007 The block SHALL have port ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 The block SHALL have port tx, output, 1 bit: the serial line, idle high.
REQ-009 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse at the end of each frame.

Function
REQ-011 The block SHALL implement the FSM states IDLE, DATA and STOP.
REQ-012 In IDLE, ready SHALL be 1, busy SHALL be 0 and tx SHALL be 1.
REQ-013 Acceptance SHALL occur on the edge where valid and ready are both 1.
- The shift register SHALL load {data_in, 1'b0}, which is M+1 bits.
- The FSM SHALL go to DATA.
- The divider counter and bit counter SHALL both clear.
REQ-014 The word SHALL go out as a frame:
- start bit 0;
- data_in[0] through data_in[M-1], LSB first;
- stop bit 1.
- Each bit SHALL be held on tx for exactly DIV cycles.
REQ-015 tx SHALL be driven directly from the shift register bit 0.
- Each shift SHALL insert 1 at the MSB, so the stop bit appears automatically after M+1 shifts.
REQ-016 In DATA, the divider SHALL count 0..DIV-1.
- On reaching DIV-1: issue one shift, increment the bit counter and reset the divider.
- After the (M+1)th shift, the FSM SHALL go to STOP.
REQ-017 In STOP, tx SHALL be 1 for DIV cycles.
- done SHALL be 1 in the last STOP cycle only.
- The FSM SHALL then return to IDLE.
REQ-018 busy SHALL be 1 exactly in DATA and STOP, for (M+2)*DIV cycles per frame; ready SHALL equal !busy.
REQ-019 Back-to-back frames:
- a word with valid held high SHALL be accepted on the first IDLE cycle after done;
- the idle gap between frames SHALL be exactly 1 cycle of tx=1.
REQ-020 While busy, valid and data_in SHALL be ignored, and the frame in flight SHALL NOT be altered.
REQ-021 With DIV=1, every bit SHALL last 1 cycle; the divider SHALL never stall the FSM.
REQ-022 Counter widths:
- divider SHALL be $clog2(DIV) bits, minimum 1;
- bit counter SHALL be $clog2(M+2) bits;
- neither counter SHALL wrap in mid-frame.

Reset
REQ-023 Asserting reset SHALL immediately apply all of the following, regardless of the clock:
- FSM to IDLE;
- shift register to all ones;
- both counters to 0;
- outputs ready=1, busy=0, done=0, tx=1.
REQ-024 Reset mid-frame SHALL abort the frame with no done pulse.
REQ-025 The first acceptance after reset deassertion SHALL be possible on the first clock edge.

Structure
REQ-026 A shared package serial_pkg SHALL hold the state enum typedef (IDLE, DATA, STOP) and the default constants for M and DIV.
REQ-027 The shift register SHALL be a separate sub-module, piso_shift_ones.
- Width: parameter M+1.
- Ports: clk, reset (async), bus_in, set, shift, bit_out.
- Reset value: all ones.
- Shift: MSB fill 1.
- set has priority over shift.
REQ-028 The FSM and the counters SHALL live in serial_frame_sender.

Verification
REQ-029 Single frame (M=5, DIV=4): data_in=5'b10110, valid pulsed once.
- tx SHALL be 0,0,1,1,0,1,1, each bit for 4 cycles.
- busy SHALL be high for 28 cycles.
- done SHALL pulse in cycle 28.
REQ-030 Back-to-back: valid held high with 5'b00001, then 5'b11111.
- Frames SHALL be separated by exactly 1 idle tx=1 cycle.
- Second frame SHALL be 0,1,1,1,1,1,1.
REQ-031 Ignore while busy: valid=1 with 5'b00000 during cycle 10 of a frame.
- The current frame SHALL be unchanged.
- The new word SHALL be accepted only after done.
REQ-032 Reset mid-frame: assert reset at cycle 12 of a frame.
- tx=1, busy=0, ready=1 SHALL hold immediately.
- No done pulse SHALL occur.
- The next frame SHALL be sent correctly.
REQ-033 DIV=1, M=1: data_in=1'b1.
- tx SHALL be 0,1,1 for 1 cycle each.
- busy SHALL last 3 cycles.
- done SHALL be on the 3rd cycle.
